// File: rtl/uram_event_buffer_manager.sv
// Occupancy tracker for NBUF event buffers between the event writer and the readout SM.
// Latency: every output is registered or decoded from registers; inputs take effect the next clk.
// Backpressure: wr_ready drops when full or flushing; writes arriving then are dropped and counted.
module uram_event_buffer_manager #(
    parameter int NBUF     = 4,
    parameter int BUF_BITS = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ev_wr_done_i,
    input  logic                rd_header_i,
    input  logic                rd_complete_i,
    input  logic                flush_i,
    output logic [BUF_BITS-1:0] wr_buf_o,
    output logic                wr_ready_o,
    output logic [BUF_BITS-1:0] rd_buf_o,
    output logic                data_available_o,
    output logic [BUF_BITS:0]   occupancy_o,
    output logic                rd_busy_o,
    output logic [CNT_BITS-1:0] ev_num_o,
    output logic [CNT_BITS-1:0] overflow_cnt_o,
    output logic                flush_done_o
);

    localparam logic [BUF_BITS:0] OCC_FULL = NBUF[BUF_BITS:0];

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_CLR  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [BUF_BITS-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [BUF_BITS:0]   occ;
    logic [CNT_BITS-1:0] ev_num, ovf_cnt;
    logic                rd_busy, flush_done;
    logic                wr_acc, wr_drop, retire;

    // Full test uses the pre-retire occupancy, so a write to a full set is dropped even on a retire.
    assign wr_acc     = ev_wr_done_i && (occ != OCC_FULL) && (state == RUN);
    assign wr_drop    = ev_wr_done_i && !wr_acc;
    assign retire     = rd_complete_i && (occ != '0);
    assign rd_ptr_nxt = retire ? rd_ptr + BUF_BITS'(1) : rd_ptr;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (flush_i) state_nxt = rd_busy ? FLUSH_WAIT : FLUSH_CLR;
            FLUSH_WAIT: if (!rd_busy) state_nxt = FLUSH_CLR;
            FLUSH_CLR:  state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            ev_num     <= '0;
            ovf_cnt    <= '0;
            rd_busy    <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_ptr     <= rd_ptr_nxt;
            flush_done <= (state == FLUSH_CLR);

            if (retire)
                ev_num <= ev_num + CNT_BITS'(1);

            if (wr_drop && (ovf_cnt != '1))
                ovf_cnt <= ovf_cnt + CNT_BITS'(1);

            if (rd_complete_i)
                rd_busy <= 1'b0;
            else if (rd_header_i)
                rd_busy <= 1'b1;

            // Flush collapses the ring onto the read pointer; event numbering continues.
            if (state == FLUSH_CLR) begin
                wr_ptr <= rd_ptr_nxt;
                occ    <= '0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + BUF_BITS'(1);
                case ({wr_acc, retire})
                    2'b10:   occ <= occ + (BUF_BITS+1)'(1);
                    2'b01:   occ <= occ - (BUF_BITS+1)'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    assign wr_buf_o         = wr_ptr;
    assign rd_buf_o         = rd_ptr;
    assign occupancy_o      = occ;
    assign rd_busy_o        = rd_busy;
    assign ev_num_o         = ev_num;
    assign overflow_cnt_o   = ovf_cnt;
    assign flush_done_o     = flush_done;
    assign data_available_o = (occ != '0) && (state == RUN);
    assign wr_ready_o       = (occ != OCC_FULL) && (state == RUN);

endmodule

// File: tb/tb_uram_event_buffer_manager.sv
// Directed bench for uram_event_buffer_manager: fill, overflow, drain, simultaneous, flush, reset.
module tb_uram_event_buffer_manager;

    localparam int NBUF     = 4;
    localparam int BUF_BITS = 2;
    localparam int CNT_BITS = 16;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                ev_wr_done_i = 1'b0;
    logic                rd_header_i = 1'b0;
    logic                rd_complete_i = 1'b0;
    logic                flush_i = 1'b0;
    logic [BUF_BITS-1:0] wr_buf_o, rd_buf_o;
    logic                wr_ready_o, data_available_o, rd_busy_o, flush_done_o;
    logic [BUF_BITS:0]   occupancy_o;
    logic [CNT_BITS-1:0] ev_num_o, overflow_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    uram_event_buffer_manager #(
        .NBUF(NBUF), .BUF_BITS(BUF_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ev_wr_done_i(ev_wr_done_i), .rd_header_i(rd_header_i),
        .rd_complete_i(rd_complete_i), .flush_i(flush_i),
        .wr_buf_o(wr_buf_o), .wr_ready_o(wr_ready_o), .rd_buf_o(rd_buf_o),
        .data_available_o(data_available_o), .occupancy_o(occupancy_o),
        .rd_busy_o(rd_busy_o), .ev_num_o(ev_num_o),
        .overflow_cnt_o(overflow_cnt_o), .flush_done_o(flush_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle pulse on the selected inputs, driven and released on falling edges.
    task automatic step(input logic wd, input logic hd, input logic cp, input logic fl);
        @(negedge clk_i);
        ev_wr_done_i  = wd;
        rd_header_i   = hd;
        rd_complete_i = cp;
        flush_i       = fl;
        @(negedge clk_i);
        ev_wr_done_i  = 1'b0;
        rd_header_i   = 1'b0;
        rd_complete_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_wr_buf"}, 32'(wr_buf_o), 0);
        chk({pfx, "_rd_buf"}, 32'(rd_buf_o), 0);
        chk({pfx, "_occ"}, 32'(occupancy_o), 0);
        chk({pfx, "_da"}, 32'(data_available_o), 0);
        chk({pfx, "_wr_ready"}, 32'(wr_ready_o), 1);
        chk({pfx, "_rd_busy"}, 32'(rd_busy_o), 0);
        chk({pfx, "_ev_num"}, 32'(ev_num_o), 0);
        chk({pfx, "_ovf"}, 32'(overflow_cnt_o), 0);
        chk({pfx, "_flush_done"}, 32'(flush_done_o), 0);
    endtask

    // Waits for the flush_done pulse with a cycle budget; returns 1 if seen.
    task automatic wait_flush_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (flush_done_o) seen = 1'b1;
            else @(negedge clk_i);
        end
        if (!seen && flush_done_o) seen = 1'b1;
    endtask

    initial begin
        bit seen;
        logic [BUF_BITS-1:0] exp_rd [4];
        exp_rd[0] = 2'd1; exp_rd[1] = 2'd2; exp_rd[2] = 2'd3; exp_rd[3] = 2'd0;

        #1;
        chk_reset_vals("rst");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Fill
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("fill_occ", 32'(occupancy_o), 4);
        chk("fill_wr_ready", 32'(wr_ready_o), 0);
        chk("fill_da", 32'(data_available_o), 1);
        chk("fill_wr_buf", 32'(wr_buf_o), 0);

        // Overflow
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("ovf_cnt", 32'(overflow_cnt_o), 2);
        chk("ovf_occ", 32'(occupancy_o), 4);
        chk("ovf_wr_buf", 32'(wr_buf_o), 0);

        // Drain
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            chk("drain_busy", 32'(rd_busy_o), 1);
            step(0, 0, 1, 0);
            chk("drain_rd_buf", 32'(rd_buf_o), 32'(exp_rd[i]));
            chk("drain_busy_clr", 32'(rd_busy_o), 0);
        end
        chk("drain_ev_num", 32'(ev_num_o), 4);
        chk("drain_da", 32'(data_available_o), 0);
        chk("drain_occ", 32'(occupancy_o), 0);

        // Retire on empty is ignored
        step(0, 0, 1, 0);
        chk("empty_ret_occ", 32'(occupancy_o), 0);
        chk("empty_ret_rd_buf", 32'(rd_buf_o), 0);
        chk("empty_ret_ev_num", 32'(ev_num_o), 4);

        // Simultaneous write + retire
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("sim_pre_occ", 32'(occupancy_o), 2);
        step(1, 0, 1, 0);
        chk("sim_occ", 32'(occupancy_o), 2);
        chk("sim_wr_buf", 32'(wr_buf_o), 3);
        chk("sim_rd_buf", 32'(rd_buf_o), 1);
        chk("sim_ev_num", 32'(ev_num_o), 5);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("simfull_pre_occ", 32'(occupancy_o), 4);
        step(1, 0, 1, 0);
        chk("simfull_occ", 32'(occupancy_o), 3);
        chk("simfull_wr_buf", 32'(wr_buf_o), 1);
        chk("simfull_rd_buf", 32'(rd_buf_o), 2);
        chk("simfull_ovf", 32'(overflow_cnt_o), 3);

        // Flush mid-read
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("fw_da", 32'(data_available_o), 0);
        chk("fw_wr_ready", 32'(wr_ready_o), 0);
        chk("fw_occ", 32'(occupancy_o), 3);
        step(1, 0, 0, 0);
        chk("fw_drop_ovf", 32'(overflow_cnt_o), 4);
        chk("fw_drop_wr_buf", 32'(wr_buf_o), 1);
        chk("fw_hold_done", 32'(flush_done_o), 0);
        step(0, 0, 1, 0);
        chk("fw_ret_occ", 32'(occupancy_o), 2);
        chk("fw_ret_ev_num", 32'(ev_num_o), 7);
        chk("fw_ret_busy", 32'(rd_busy_o), 0);
        wait_flush_done(seen);
        chk("fl_done_seen", 32'(seen), 1);
        chk("fl_occ", 32'(occupancy_o), 0);
        chk("fl_wr_buf", 32'(wr_buf_o), 3);
        chk("fl_rd_buf", 32'(rd_buf_o), 3);
        chk("fl_ev_num", 32'(ev_num_o), 7);
        chk("fl_wr_ready", 32'(wr_ready_o), 1);
        @(negedge clk_i);
        chk("fl_done_pulse", 32'(flush_done_o), 0);

        // Flush while idle goes straight through
        step(1, 0, 0, 0);
        chk("idle_pre_wr_buf", 32'(wr_buf_o), 0);
        step(0, 0, 0, 1);
        wait_flush_done(seen);
        chk("idle_fl_seen", 32'(seen), 1);
        chk("idle_fl_occ", 32'(occupancy_o), 0);
        chk("idle_fl_wr_buf", 32'(wr_buf_o), 3);

        // Async reset mid-readout
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("ar_pre_occ", 32'(occupancy_o), 2);
        chk("ar_pre_busy", 32'(rd_busy_o), 1);
        #2 rst_i = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(negedge clk_i);
        rst_i = 1'b0;
        step(1, 0, 0, 0);
        chk("post_rst_occ", 32'(occupancy_o), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
